// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the i2s sample scheduler.
//   state_t      - frame sequencer states
//   BUSY_TIMEOUT - cycles to wait for the serializer to drop ready after a send
//   DEF_WIDTH    - default sample width per channel
//   MIN_PERIOD   - smallest usable frame period in clk cycles
package i2s_pkg;
   typedef enum logic [1:0] {IDLE, SEND, BUSY, DONE} state_t;
   localparam int BUSY_TIMEOUT = 4;
   localparam int DEF_WIDTH = 16;
   localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/i2s_sample_scheduler_if.sv
// i2s_sample_scheduler_if: producer handshake and serializer bus of the scheduler.
//   in_valid/in_ready/in_left/in_right      - stereo pair push handshake
//   i2s_ready/i2s_send/i2s_word_length/
//   i2s_left/i2s_right                      - serializer control and data
//   slave modport: scheduler side; master modport: producer + serializer side
interface i2s_sample_scheduler_if #(parameter int WIDTH = i2s_pkg::DEF_WIDTH);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_left;
   logic [WIDTH-1:0] in_right;
   logic             i2s_ready;
   logic             i2s_send;
   logic [7:0]       i2s_word_length;
   logic [WIDTH-1:0] i2s_left;
   logic [WIDTH-1:0] i2s_right;
   modport slave (
      input  in_valid, in_left, in_right, i2s_ready,
      output in_ready, i2s_send, i2s_word_length, i2s_left, i2s_right
   );
   modport master (
      output in_valid, in_left, in_right, i2s_ready,
      input  in_ready, i2s_send, i2s_word_length, i2s_left, i2s_right
   );
endinterface

// File: rtl/sample_fifo.sv
// sample_fifo: W x DEPTH synchronous FIFO with occupancy output.
//   clk, reset    - clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   - write request and data; accepted only when ready
//   ready         - not full (from registered fill, so a pop never frees a slot early)
//   pop           - read request; ignored when empty
//   rdata, empty  - head of the FIFO (valid when !empty)
//   fill          - current occupancy
module sample_fifo import i2s_pkg::*; #(
   parameter int W     = 2 * DEF_WIDTH,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           wdata,
   output logic                   ready,
   output logic                   empty,
   output logic [W-1:0]           rdata,
   output logic [$clog2(DEPTH):0] fill
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          wr, rd;
   assign ready = fill != FW'(DEPTH);
   assign empty = fill == '0;
   assign wr    = push && ready;
   assign rd    = pop && !empty;
   assign rdata = mem[rp];
   always_ff @(posedge clk) begin
      if (reset) begin
         wp   <= '0;
         rp   <= '0;
         fill <= '0;
      end else begin
         wp   <= wp + AW'(wr);
         rp   <= rp + AW'(rd);
         fill <= fill + FW'(wr) - FW'(rd);
      end
   end
   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= wdata;
   end
endmodule

// File: rtl/i2s_sample_scheduler.sv
// i2s_sample_scheduler: paces an i2s serializer at a programmable frame rate from a pair FIFO.
//   clk, reset        - clock, synchronous active-high reset
//   enable            - runs the frame tick generator
//   sample_period     - clk cycles per frame (0 and 1 behave as 2)
//   word_length       - bits per channel, captured at each send
//   bus               - producer handshake and serializer bus (slave side)
//   fill              - FIFO occupancy
//   underrun_count    - saturating count of frames sent with an empty FIFO
//   overrun_count     - saturating count of ticks that found a frame still pending
module i2s_sample_scheduler import i2s_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = 8,
   parameter int DIV_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [DIV_W-1:0]       sample_period,
   input  logic [7:0]             word_length,
   i2s_sample_scheduler_if.slave  bus,
   output logic [$clog2(DEPTH):0] fill,
   output logic [15:0]            underrun_count,
   output logic [15:0]            overrun_count
);
   localparam int TW = $clog2(BUSY_TIMEOUT);
   state_t             state, state_n;
   logic [DIV_W-1:0]   cnt, period;
   logic [TW-1:0]      tmr;
   logic               pending, tick, go, empty, pop;
   logic [2*WIDTH-1:0] head;
   logic [WIDTH-1:0]   left_q, right_q;
   logic [7:0]         wl_q;
   assign period = sample_period < DIV_W'(MIN_PERIOD) ? DIV_W'(MIN_PERIOD) : sample_period;
   // >= rather than == so a period shortened below the current count wraps at once
   assign tick = enable && cnt >= period - DIV_W'(1);
   assign go   = state == IDLE && pending && bus.i2s_ready;
   assign pop  = state == SEND && !empty;
   sample_fifo #(.W(2 * WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.in_valid),
      .pop   (pop),
      .wdata ({bus.in_left, bus.in_right}),
      .ready (bus.in_ready),
      .empty (empty),
      .rdata (head),
      .fill  (fill)
   );
   always_comb begin
      state_n             = state;
      bus.i2s_send        = state == SEND;
      bus.i2s_left        = left_q;
      bus.i2s_right       = right_q;
      bus.i2s_word_length = wl_q;
      unique case (state)
         IDLE: state_n = go ? SEND : IDLE;
         SEND: begin
            state_n             = BUSY;
            bus.i2s_left        = empty ? '0 : head[2*WIDTH-1:WIDTH];
            bus.i2s_right       = empty ? '0 : head[WIDTH-1:0];
            bus.i2s_word_length = word_length;
         end
         // a serializer that never drops ready ignored the strobe; give up after the timeout
         BUSY: state_n = !bus.i2s_ready ? DONE : tmr == TW'(BUSY_TIMEOUT - 1) ? IDLE : BUSY;
         DONE: state_n = bus.i2s_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         tmr            <= '0;
         pending        <= 1'b0;
         left_q         <= '0;
         right_q        <= '0;
         wl_q           <= '0;
         underrun_count <= '0;
         overrun_count  <= '0;
      end else begin
         state   <= state_n;
         cnt     <= !enable || tick ? '0 : cnt + DIV_W'(1);
         tmr     <= state == BUSY ? tmr + TW'(1) : '0;
         // a tick coinciding with SEND entry starts a fresh frame instead of overrunning
         pending <= enable && (tick || (pending && !go));
         if (tick && pending && !go && overrun_count != '1) overrun_count <= overrun_count + 16'd1;
         if (state == SEND) begin
            left_q  <= bus.i2s_left;
            right_q <= bus.i2s_right;
            wl_q    <= word_length;
            if (empty && underrun_count != '1) underrun_count <= underrun_count + 16'd1;
         end
      end
   end
endmodule
